// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator: FSM state
// encoding, tuser field layout and the MSB-aligned byte-enable helper.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_e;

  // tuser = {pkt_len_bytes, src_mac, eth_type}
  localparam int TUSER_W  = 80;
  localparam int LEN_W    = 16;
  localparam int LEN_LSB  = 64;
  localparam int MAC_W    = 48;
  localparam int MAC_LSB  = 16;
  localparam int TYPE_W   = 16;
  localparam int TYPE_LSB = 0;

  // Widest tkeep supported (512-bit data bus).
  localparam int KEEP_MAX = 64;

  // Sets the n most significant of the low w bits; the caller slices to w.
  function automatic logic [KEEP_MAX-1:0] keep_from_bytes(input int n, input int w);
    logic [KEEP_MAX-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (i < w && i >= w - n) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_keep_gen.sv
// Byte count to MSB-aligned tkeep for the last beat of a packet.
// The count is expected to be already clamped to 1..P_KEEP_W.
module axis_keep_gen import axis_gen_pkg::*; #(
  parameter  int P_KEEP_W = 8,
  localparam int CNT_W    = $clog2(P_KEEP_W) + 1
) (
  input  logic [CNT_W-1:0]    i_bytes,
  output logic [P_KEEP_W-1:0] o_keep
);

  // Pure decode, no state.
  always_comb begin
    o_keep = P_KEEP_W'(keep_from_bytes(int'(i_bytes), P_KEEP_W));
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream test packet generator. A run of packets is configured at start;
// each beat carries its index replicated across tdata, the last beat carries a
// fixed or sweeping byte count, and tuser carries the packet length in bytes.
module axis_pkt_gen import axis_gen_pkg::*; #(
  parameter  int          P_DATA_W   = 64,
  parameter  logic [47:0] P_SRC_MAC  = 48'h0102_0304_0506,
  parameter  logic [15:0] P_ETH_TYPE = 16'h0800,
  localparam int          P_KEEP_W   = P_DATA_W / 8,
  localparam int          LB_W       = $clog2(P_KEEP_W) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [15:0]         i_pkt_len,
  input  logic [15:0]         i_pkt_num,
  input  logic [7:0]          i_gap,
  input  logic                i_sweep,
  input  logic [LB_W-1:0]     i_last_bytes,
  output logic [P_DATA_W-1:0] m_axis_tdata,
  output logic [TUSER_W-1:0]  m_axis_tuser,
  output logic [P_KEEP_W-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                s_axis_tready,
  output logic                o_busy,
  output logic                o_done,
  output logic [15:0]         o_pkt_cnt
);

  localparam int REP = P_DATA_W / 16;

  gen_state_e state_q, state_d;

  logic [15:0]         len_q, num_q, beat_q, pkt_cnt_q;
  logic [7:0]          gap_q, gap_cnt_q;
  logic                sweep_q, done_q;
  logic [LB_W-1:0]     last_bytes_q, sw_idx_q, n_bytes;
  logic                hs, last_beat, pkt_end, final_pkt;
  logic [15:0]         pkt_bytes;
  logic [P_KEEP_W-1:0] keep_last;

  assign hs        = m_axis_tvalid & s_axis_tready;
  assign last_beat = (beat_q == len_q - 16'd1);
  assign pkt_end   = hs & last_beat;
  // i_stop is honoured only at a packet boundary so a packet is never cut short.
  assign final_pkt = i_stop || (num_q != 16'd0 && (pkt_cnt_q + 16'd1) == num_q);

  // sw_idx_q tracks packet index mod P_KEEP_W without a divider.
  assign n_bytes   = sweep_q ? (LB_W'(P_KEEP_W) - sw_idx_q) : last_bytes_q;
  assign pkt_bytes = ((len_q - 16'd1) * 16'(P_KEEP_W)) + 16'(n_bytes);

  axis_keep_gen #(.P_KEEP_W(P_KEEP_W)) u_keep_gen (
    .i_bytes (n_bytes),
    .o_keep  (keep_last)
  );

  // State register; reset drops tvalid immediately since tvalid decodes state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_SEND;
      ST_SEND: begin
        if (pkt_end) begin
          if (final_pkt)            state_d = ST_IDLE;
          else if (gap_q != 8'd0)   state_d = ST_GAP;
          else                      state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (i_stop)                 state_d = ST_IDLE;
        else if (gap_cnt_q == 8'd1) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run configuration, beat/packet counters, gap down-counter and done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q        <= 16'd1;
      num_q        <= 16'd1;
      gap_q        <= 8'd0;
      sweep_q      <= 1'b0;
      last_bytes_q <= LB_W'(P_KEEP_W);
      beat_q       <= 16'd0;
      pkt_cnt_q    <= 16'd0;
      sw_idx_q     <= '0;
      gap_cnt_q    <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
      if (state_q == ST_IDLE && i_start) begin
        len_q        <= (i_pkt_len == 16'd0) ? 16'd1 : i_pkt_len;
        num_q        <= i_pkt_num;
        gap_q        <= i_gap;
        sweep_q      <= i_sweep;
        last_bytes_q <= (i_last_bytes == '0 || i_last_bytes > LB_W'(P_KEEP_W))
                        ? LB_W'(P_KEEP_W) : i_last_bytes;
        beat_q       <= 16'd0;
        pkt_cnt_q    <= 16'd0;
        sw_idx_q     <= '0;
      end
      if (hs) begin
        if (last_beat) begin
          beat_q    <= 16'd0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
          sw_idx_q  <= (sw_idx_q == LB_W'(P_KEEP_W - 1)) ? '0 : sw_idx_q + LB_W'(1);
        end else begin
          beat_q <= beat_q + 16'd1;
        end
      end
      if (state_q == ST_SEND && state_d == ST_GAP) gap_cnt_q <= gap_q;
      else if (state_q == ST_GAP)                  gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  // Output decode; everything derives from registers so it holds until handshake.
  always_comb begin
    m_axis_tvalid = (state_q == ST_SEND);
    m_axis_tlast  = m_axis_tvalid & last_beat;
    m_axis_tdata  = {REP{beat_q}};
    m_axis_tkeep  = m_axis_tlast ? keep_last : '1;
    m_axis_tuser  = '0;
    if (m_axis_tvalid) begin
      m_axis_tuser[LEN_LSB  +: LEN_W]  = pkt_bytes;
      m_axis_tuser[MAC_LSB  +: MAC_W]  = P_SRC_MAC;
      m_axis_tuser[TYPE_LSB +: TYPE_W] = P_ETH_TYPE;
    end
    o_busy    = (state_q != ST_IDLE);
    o_done    = done_q;
    o_pkt_cnt = pkt_cnt_q;
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed runs plus randomized runs with
// random backpressure, checked against a packet-level reference model.
module tb_axis_pkt_gen;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int LBW = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic            i_stop = 1'b0;
  logic [15:0]     i_pkt_len = 16'd1;
  logic [15:0]     i_pkt_num = 16'd1;
  logic [7:0]      i_gap = 8'd0;
  logic            i_sweep = 1'b0;
  logic [LBW-1:0]  i_last_bytes = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic [79:0]     m_axis_tuser;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            s_axis_tready = 1'b1;
  logic            o_busy;
  logic            o_done;
  logic [15:0]     o_pkt_cnt;

  axis_pkt_gen #(.P_DATA_W(DW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_pkt_len     (i_pkt_len),
    .i_pkt_num     (i_pkt_num),
    .i_gap         (i_gap),
    .i_sweep       (i_sweep),
    .i_last_bytes  (i_last_bytes),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [79:0]   user;
  } beat_t;

  beat_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int rdy_pct = 100;

  bit           mon_en = 1'b0;
  int           acc_pkts, cur_beat, gap_seen, exp_gap, done_cnt;
  bit           in_gap, hold_v;
  logic [DW+KW:0] hold_dkl;
  logic [79:0]  hold_user;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: the beats a run should produce, straight from the packet rules.
  task automatic build(input int len, input int npk, input bit sw, input int lb);
    int l, n, ulen;
    beat_t b;
    logic [15:0] kk;
    l = (len == 0) ? 1 : len;
    for (int p = 0; p < npk; p++) begin
      n    = sw ? (KW - (p % KW)) : ((lb == 0 || lb > KW) ? KW : lb);
      ulen = ((l - 1) * KW + n) & 32'hFFFF;
      for (int k = 0; k < l; k++) begin
        kk     = k[15:0];
        b.data = {kk, kk, kk, kk};
        b.last = (k == l - 1);
        b.keep = b.last ? KW'(((1 << n) - 1) << (KW - n)) : {KW{1'b1}};
        b.user = {ulen[15:0], 48'h0102_0304_0506, 16'h0800};
        exp_q.push_back(b);
      end
    end
  endtask

  // Random backpressure, changed just after each rising edge.
  initial forever begin
    @(posedge i_clk);
    #1;
    s_axis_tready = ($urandom_range(99) < rdy_pct);
  end

  // Monitor: beat contents, stability under backpressure, gaps, packet count.
  initial forever begin
    beat_t e;
    @(negedge i_clk);
    if (mon_en) begin
      if (o_done) done_cnt++;
      check("pkt_cnt_live", o_pkt_cnt, acc_pkts[15:0]);
      if (hold_v) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_dkl", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, hold_dkl);
        check("hold_user", m_axis_tuser, hold_user);
      end
      hold_v    = m_axis_tvalid && !s_axis_tready;
      hold_dkl  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      hold_user = m_axis_tuser;
      if (m_axis_tvalid) begin
        if (in_gap) begin
          check("gap_len", gap_seen, exp_gap);
          in_gap = 1'b0;
        end
      end else if (in_gap) begin
        gap_seen++;
      end
      if (m_axis_tvalid && s_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", m_axis_tdata, '0 - 1);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tkeep", m_axis_tkeep, e.keep);
          check("tlast", m_axis_tlast, e.last);
          check("tuser", m_axis_tuser, e.user);
          cur_beat++;
          if (e.last) begin
            acc_pkts++;
            cur_beat = 0;
            in_gap   = 1'b1;
            gap_seen = 0;
          end
        end
      end
    end
  end

  // stop_mode: 0 none, 1 stop mid-packet stop_pkt (1-based), 2 stop in gap after stop_pkt packets.
  task automatic run_pkt(input int len, input int num, input int gap, input bit sw,
                         input int lb, input int rdy, input int exp_pkts,
                         input int stop_mode, input int stop_pkt, input bit spur);
    int budget, cyc, l;
    l = (len == 0) ? 1 : len;
    exp_q.delete();
    build(len, exp_pkts, sw, lb);
    budget  = 4 * l * exp_pkts + exp_pkts * (gap + 2) + 100;
    rdy_pct = rdy;
    @(posedge i_clk);
    #1;
    i_pkt_len    = len[15:0];
    i_pkt_num    = num[15:0];
    i_gap        = gap[7:0];
    i_sweep      = sw;
    i_last_bytes = lb[LBW-1:0];
    i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    i_start   = 1'b0;
    // Configuration is sampled at start; scramble it to prove that.
    i_pkt_len = 16'($urandom);
    i_pkt_num = 16'($urandom);
    i_gap     = 8'($urandom);
    i_sweep   = ~sw;
    acc_pkts = 0; cur_beat = 0; in_gap = 1'b0; gap_seen = 0;
    exp_gap  = gap; done_cnt = 0; hold_v = 1'b0;
    mon_en   = 1'b1;
    @(negedge i_clk);
    check("first_valid", m_axis_tvalid, 1'b1);
    check("busy_run", o_busy, 1'b1);
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      i_start = (spur && cyc == 3);
      if (stop_mode == 1 && acc_pkts == stop_pkt - 1 && cur_beat >= 2) i_stop = 1'b1;
      if (stop_mode == 2 && acc_pkts == stop_pkt && in_gap && gap_seen >= 2) i_stop = 1'b1;
    end
    i_start = 1'b0;
    check("done_seen", done_cnt, 1);
    repeat (3) @(negedge i_clk);
    check("done_pulses", done_cnt, 1);
    check("busy_end", o_busy, 1'b0);
    check("beats_left", exp_q.size(), 0);
    check("pkt_cnt_end", o_pkt_cnt, exp_pkts[15:0]);
    mon_en = 1'b0;
    i_stop = 1'b0;
  endtask

  initial begin
    int cyc, len, num, gap, lb;
    bit sw;

    // Reset values.
    #12;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_pkt_cnt", o_pkt_cnt, 16'd0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tkeep", m_axis_tkeep, 8'hFF);
    check("rst_tuser", m_axis_tuser, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic 4-beat packet.
    run_pkt(4, 1, 0, 1'b0, 0, 100, 1, 0, 0, 1'b0);
    // Sweep across ten 186-beat packets.
    run_pkt(186, 10, 0, 1'b1, 0, 100, 10, 0, 0, 1'b0);
    // Inter-packet gap of 5.
    run_pkt(2, 3, 5, 1'b0, 8, 100, 3, 0, 0, 1'b0);
    // Single-beat packets with a zero length request and odd byte count.
    run_pkt(0, 3, 1, 1'b0, 3, 100, 3, 0, 0, 1'b0);

    // Randomized runs under 50% backpressure.
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(12);
      num = $urandom_range(4, 1);
      gap = $urandom_range(3);
      sw  = 1'($urandom);
      lb  = $urandom_range(15);
      run_pkt(len, num, gap, sw, lb, 50, num, 0, 0,
              (it % 2 == 0) && (((len == 0) ? 1 : len) * num >= 6));
    end

    // Continuous run stopped in the middle of packet 2.
    run_pkt(8, 0, 0, 1'b0, 5, 100, 2, 1, 2, 1'b0);
    // Continuous run stopped during the gap after packet 1.
    run_pkt(3, 0, 6, 1'b0, 3, 100, 1, 2, 1, 1'b0);

    // Reset at beat 50 of a long packet, then a clean restart.
    rdy_pct = 100;
    @(posedge i_clk);
    #1;
    i_pkt_len = 16'd186; i_pkt_num = 16'd1; i_gap = 8'd0; i_sweep = 1'b0; i_last_bytes = '0;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    cyc = 0;
    while (!(m_axis_tvalid && m_axis_tdata[15:0] == 16'd50) && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
    end
    check("reach_beat50", m_axis_tdata[15:0], 16'd50);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tlast", m_axis_tlast, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_pkt_cnt", o_pkt_cnt, 16'd0);
    check("mid_rst_tdata", m_axis_tdata, '0);
    check("mid_rst_tkeep", m_axis_tkeep, 8'hFF);
    check("mid_rst_tuser", m_axis_tuser, '0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("no_resume", m_axis_tvalid, 1'b0);
    run_pkt(186, 1, 0, 1'b0, 0, 100, 1, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
